// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: IF/ID decoded fields, write-back port and the registered ID/EX outputs.
// Handshake: an instruction moves into ID/EX at an edge when in_valid=1, stall=0, flush=0; while stall=1 upstream holds the same instruction.
interface id_ex_stage_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic [XLEN-1:0] pc;
   logic [2:0]      inst_type;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [4:0]      rs;
   logic [4:0]      rs2;
   logic [5:0]      funct7;
   logic [XLEN-1:0] imm;
   logic            flush;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            stall;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic [2:0]      ex_inst_type;
   logic [2:0]      ex_funct3;
   logic [5:0]      ex_funct7;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs;
   logic [4:0]      ex_rs2;
   logic [XLEN-1:0] ex_rs_val;
   logic [XLEN-1:0] ex_rs2_val;

   modport slave (
      input  in_valid, pc, inst_type, rd, funct3, rs, rs2, funct7, imm, flush,
             wb_en, wb_rd, wb_data,
      output stall, ex_valid, ex_pc, ex_imm, ex_inst_type, ex_funct3, ex_funct7,
             ex_rd, ex_rs, ex_rs2, ex_rs_val, ex_rs2_val
   );

   modport master (
      output in_valid, pc, inst_type, rd, funct3, rs, rs2, funct7, imm, flush,
             wb_en, wb_rd, wb_data,
      input  stall, ex_valid, ex_pc, ex_imm, ex_inst_type, ex_funct3, ex_funct7,
             ex_rd, ex_rs, ex_rs2, ex_rs_val, ex_rs2_val
   );
endinterface

// File: rtl/id_ex_stage.sv
// Decode/operand-fetch stage: 32x32 register file with write-through read, load-use
// hazard detection and the ID/EX pipeline register.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);
   localparam logic [2:0] T_R      = 3'd0;
   localparam logic [2:0] T_IALU   = 3'd1;
   localparam logic [2:0] T_LOAD   = 3'd2;
   localparam logic [2:0] T_STORE  = 3'd3;
   localparam logic [2:0] T_BRANCH = 3'd4;
   localparam logic [2:0] T_JALR   = 3'd6;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [2:0]      inst_type;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [4:0]      rs;
      logic [4:0]      rs2;
      logic [5:0]      funct7;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rs_val;
      logic [XLEN-1:0] rs2_val;
   } ex_t;

   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   ex_t             ex_q, ex_d;
   logic [XLEN-1:0] rs_val, rs2_val;
   logic            use_rs, use_rs2, hazard, stall;

   always_comb begin
      rf_d = rf_q;
      if (bus.wb_en && bus.wb_rd != 5'd0) rf_d[bus.wb_rd] = bus.wb_data;
   end

   // Write-through: a write-back landing this cycle is visible to this cycle's read.
   always_comb begin
      rs_val  = '0;
      rs2_val = '0;
      if (bus.rs != 5'd0)
         rs_val = (bus.wb_en && bus.wb_rd == bus.rs) ? bus.wb_data : rf_q[bus.rs];
      if (bus.rs2 != 5'd0)
         rs2_val = (bus.wb_en && bus.wb_rd == bus.rs2) ? bus.wb_data : rf_q[bus.rs2];
   end

   always_comb begin
      use_rs  = 1'b0;
      use_rs2 = 1'b0;
      case (bus.inst_type)
         T_R, T_STORE, T_BRANCH: begin
            use_rs  = 1'b1;
            use_rs2 = 1'b1;
         end
         T_IALU, T_LOAD, T_JALR: use_rs = 1'b1;
         default: ;
      endcase
   end

   // The bubble clears ex_valid, so a load-use stall never lasts more than one cycle.
   always_comb begin
      hazard = bus.in_valid && ex_q.valid && ex_q.inst_type == T_LOAD && ex_q.rd != 5'd0 &&
               ((use_rs && bus.rs == ex_q.rd) || (use_rs2 && bus.rs2 == ex_q.rd));
      stall  = hazard && !bus.flush;
   end

   always_comb begin
      ex_d = ex_q;
      if (bus.flush || stall) begin
         ex_d.valid = 1'b0;
      end else begin
         ex_d.valid     = bus.in_valid;
         ex_d.pc        = bus.pc;
         ex_d.inst_type = bus.inst_type;
         ex_d.rd        = bus.rd;
         ex_d.funct3    = bus.funct3;
         ex_d.rs        = bus.rs;
         ex_d.rs2       = bus.rs2;
         ex_d.funct7    = bus.funct7;
         ex_d.imm       = bus.imm;
         ex_d.rs_val    = rs_val;
         ex_d.rs2_val   = rs2_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q <= '0;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         ex_q <= ex_d;
         rf_q <= rf_d;
      end
   end

   assign bus.stall        = stall;
   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_inst_type = ex_q.inst_type;
   assign bus.ex_funct3    = ex_q.funct3;
   assign bus.ex_funct7    = ex_q.funct7;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.ex_rs        = ex_q.rs;
   assign bus.ex_rs2       = ex_q.rs2;
   assign bus.ex_rs_val    = ex_q.rs_val;
   assign bus.ex_rs2_val   = ex_q.rs2_val;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand-fetch stage directly downstream of the IF/ID pipeline register; consumes its decoded fields.
- Holds the 32x32 integer register file with a write-back port and detects load-use hazards.
- Produces the registered ID/EX bundle (operand values plus control) consumed by execute.
- Single-cycle pipeline slot with stall output to upstream and flush input from branch resolution.

Parameters:
- XLEN, 32, data/PC width
- NREGS, 32, register count; index width 5

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  IF/ID slot holds a real instruction
- pc  in  XLEN  instruction PC
- inst_type  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 U
- rd  in  5  destination index
- funct3  in  3  funct3 field
- rs  in  5  source 1 index
- rs2  in  5  source 2 index
- funct7  in  6  funct7 field as produced upstream
- imm  in  XLEN  sign-extended immediate
- flush  in  1  kill the instruction entering ID/EX this cycle
- wb_en  in  1  write-back strobe
- wb_rd  in  5  write-back index
- wb_data  in  XLEN  write-back value
- stall  out  1  combinational; upstream holds PC and IF/ID while high
- ex_valid  out  1  ID/EX slot valid
- ex_pc, ex_imm  out  XLEN  registered copies
- ex_inst_type  out  3  registered copy
- ex_funct3  out  3  registered copy
- ex_funct7  out  6  registered copy
- ex_rd, ex_rs, ex_rs2  out  5  registered copies (forwarding unit uses ex_rs/ex_rs2)
- ex_rs_val, ex_rs2_val  out  XLEN  operand values

Behaviour:
- Reset (rst_n=0 at edge): all ex_* outputs 0, ex_valid 0, all 32 registers cleared to 0; reset beats wb_en.
- Register file write: at edge when wb_en=1 and wb_rd!=0; writes to x0 are ignored; x0 always reads 0.
- Read is combinational with write-through bypass: if wb_en and wb_rd==index and index!=0, return wb_data.
- Source usage:
  - R, STORE, BRANCH use rs and rs2.
  - I-ALU, LOAD, JALR use rs only.
  - JAL and U use neither.
- Load-use hazard:
  - hazard = in_valid & ex_valid & ex_inst_type==LOAD & ex_rd!=0 & (used rs==ex_rd or used rs2==ex_rd).
  - stall = hazard & ~flush.
- Update at each edge (rst_n=1), first matching rule applies:
  - flush=1: ex_valid<=0; other ex_* don't-care, hold permitted.
  - stall=1: ex_valid<=0 (bubble inserted); upstream re-presents the same instruction next cycle.
  - otherwise: ex_valid<=in_valid; all ex_* <= inputs and read values, 1-cycle latency.
- A stall lasts exactly one cycle: after the bubble, ex_valid=0, so hazard clears.
- Simultaneous write-back to a register being read: the bypass delivers the new value in the same cycle.
- Unused operand slots still carry the register-read value; execute ignores them by type.

Test Plan:
- Reset with wb_en=1, wb_rd=5: after release, read of x5 gives 0; ex_valid=0 and stall=0.
- wb x3=0xDEADBEEF at cycle N, then R-type rs=3, rs2=0 at N+1: ex_rs_val=0xDEADBEEF and ex_rs2_val=0 at N+2.
- R-type rs=7 in the same cycle as wb x7=0x1234: ex_rs_val=0x1234 next edge (bypass); wb_rd=0 with data 0xFFFF leaves x0=0.
- LOAD rd=4 followed by BRANCH rs2=4: stall=1 for one cycle and a bubble is inserted (ex_valid=0); next cycle the BRANCH enters with ex_valid=1.
- LOAD rd=4 followed by JAL or U type (no use of x4): no stall. LOAD rd=0 followed by a use of x0: no stall.
- Hazard cycle with flush=1: stall=0 and ex_valid=0 next cycle. in_valid=0: ex_valid=0 and stall=0.
